// File: rtl/mast_pkg.sv
// Shared AHB-Lite encodings used by the mast bus master and its bench.
package mast_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Incrementing address step; hsize is deliberately not clamped.
  function automatic logic [31:0] incr_addr(input logic [31:0] addr, input logic [2:0] size);
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/mast_if.sv
// Local request side plus AHB-Lite master signals, grouped for the mast block.
interface mast_if;
  import mast_pkg::*;

  logic        start;
  logic        burst;
  logic        data_ready;
  logic        hwrite_in;
  logic [31:0] haddrin;
  logic [31:0] hwdatain;
  logic [2:0]  hsize_in;
  logic [1:0]  offset_in;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [1:0]  offset;
  logic [31:0] hwdata;
  logic [31:0] hrdata_out;

  modport master (
    input  start, burst, data_ready, hwrite_in, haddrin, hwdatain, hsize_in, offset_in,
    input  hready, hresp, hrdata,
    output haddr, hwrite, hsize, hburst, htrans, offset, hwdata, hrdata_out
  );

  modport slave (
    output start, burst, data_ready, hwrite_in, haddrin, hwdatain, hsize_in, offset_in,
    output hready, hresp, hrdata,
    input  haddr, hwrite, hsize, hburst, htrans, offset, hwdata, hrdata_out
  );
endinterface

// File: rtl/mast.sv
// AHB-Lite master: turns start/burst/data_ready requests into pipelined
// address and data phases with SINGLE/INCR bursts, BUSY, wait states and ERROR.
module mast
  import mast_pkg::*;
(
  input  logic   hclk,
  input  logic   hresetn,
  mast_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_BUSY   = 2'(BUSY);
  localparam logic [1:0] S_NONSEQ = 2'(NONSEQ);
  localparam logic [1:0] S_SEQ    = 2'(SEQ);

  logic [1:0]  r_state;
  logic [31:0] r_haddr;
  logic        r_hwrite;
  logic [2:0]  r_hsize;
  logic [2:0]  r_hburst;
  logic [1:0]  r_offset;
  logic [31:0] r_hwdata;
  logic [31:0] r_hrdata;
  logic        r_rd_pend;

  logic [1:0]  w_nxt;
  logic        w_latch;
  logic        w_incr;
  logic        w_new;
  logic        w_cont;
  logic        w_beat;

  assign w_new  = bus.start & bus.data_ready;
  assign w_cont = bus.start & bus.burst;
  // NONSEQ and SEQ are the only encodings with bit 1 set.
  assign w_beat = r_state[1];

  always_comb begin
    w_nxt   = r_state;
    w_latch = 1'b0;
    w_incr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_new) begin
          w_nxt   = S_NONSEQ;
          w_latch = 1'b1;
        end
      end
      S_NONSEQ, S_SEQ: begin
        if (w_cont) begin
          if (bus.data_ready) begin
            w_nxt  = S_SEQ;
            w_incr = 1'b1;
          end else begin
            w_nxt = S_BUSY;
          end
        end else if (w_new) begin
          w_nxt   = S_NONSEQ;
          w_latch = 1'b1;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_cont) begin
          if (bus.data_ready) begin
            w_nxt  = S_SEQ;
            w_incr = 1'b1;
          end
        end else begin
          w_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Address phase: frozen while hready is low, except the first ERROR cycle forces IDLE.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      r_state  <= S_IDLE;
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= '0;
      r_hburst <= HBURST_SINGLE;
      r_offset <= '0;
    end else if (bus.hresp && !bus.hready) begin
      r_state <= S_IDLE;
    end else if (bus.hready) begin
      r_state <= w_nxt;
      if (w_latch) begin
        r_haddr  <= bus.haddrin;
        r_hwrite <= bus.hwrite_in;
        r_hsize  <= bus.hsize_in;
        r_offset <= bus.offset_in;
        r_hburst <= bus.burst ? HBURST_INCR : HBURST_SINGLE;
      end else if (w_incr) begin
        r_haddr <= incr_addr(r_haddr, r_hsize);
      end
    end
  end

  // Data phase: follows each accepted NONSEQ/SEQ address by one hready cycle.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      r_hwdata  <= '0;
      r_hrdata  <= '0;
      r_rd_pend <= 1'b0;
    end else if (bus.hready) begin
      if (w_beat && r_hwrite) r_hwdata <= bus.hwdatain;
      if (r_rd_pend && !bus.hresp) r_hrdata <= bus.hrdata;
      r_rd_pend <= w_beat & ~r_hwrite;
    end
  end

  assign bus.haddr      = r_haddr;
  assign bus.hwrite     = r_hwrite;
  assign bus.hsize      = r_hsize;
  assign bus.hburst     = r_hburst;
  assign bus.htrans     = r_state;
  assign bus.offset     = r_offset;
  assign bus.hwdata     = r_hwdata;
  assign bus.hrdata_out = r_hrdata;

endmodule

// File: tb/tb_mast.sv
// Bench for mast: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level reference model.
module tb_mast;
  import mast_pkg::*;

  logic hclk = 1'b0;
  logic hresetn;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  mast_if bus();

  mast dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  // Reference model state: what the bus must show after the most recent edge.
  htrans_t     m_tr;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wr;
  logic [2:0]  m_size, m_burst;
  logic [1:0]  m_off;
  bit          m_read_owed;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic open_request();
    m_tr    = NONSEQ;
    m_addr  = bus.haddrin;
    m_wr    = bus.hwrite_in;
    m_size  = bus.hsize_in;
    m_off   = bus.offset_in;
    m_burst = bus.burst ? HBURST_INCR : HBURST_SINGLE;
  endtask

  task automatic model_edge();
    bit beat_done;
    bit keep_going;
    if (hresetn) begin
      m_tr = IDLE; m_addr = 0; m_wr = 0; m_size = 0; m_burst = HBURST_SINGLE;
      m_off = 0; m_wdata = 0; m_rdata = 0; m_read_owed = 0;
      return;
    end
    if (!bus.hready) begin
      if (bus.hresp) m_tr = IDLE;
      return;
    end
    // Data phase bookkeeping for the beat that was on the bus before this edge.
    beat_done = (m_tr == NONSEQ) || (m_tr == SEQ);
    if (m_read_owed && !bus.hresp) m_rdata = bus.hrdata;
    if (beat_done && m_wr) m_wdata = bus.hwdatain;
    m_read_owed = beat_done && !m_wr;
    // Address phase: continue the burst, pause it, or start/stop.
    keep_going = bus.start && bus.burst;
    if (m_tr == IDLE) begin
      if (bus.start && bus.data_ready) open_request();
    end else if (keep_going) begin
      if (bus.data_ready) begin
        m_tr   = SEQ;
        m_addr = m_addr + (32'd1 << m_size);
      end else begin
        m_tr = BUSY;
      end
    end else if (m_tr != BUSY && bus.start && bus.data_ready) begin
      open_request();
    end else begin
      m_tr = IDLE;
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    model_edge();
    cmp_en = 1'b1;
    #1;
  endtask

  always @(negedge hclk) begin
    if (cmp_en) begin
      chk("m_htrans", 32'(bus.htrans), 32'(m_tr));
      chk("m_haddr", bus.haddr, m_addr);
      chk("m_ctrl", {24'd0, bus.hwrite, bus.hsize, bus.hburst, bus.offset[0]},
                    {24'd0, m_wr, m_size, m_burst, m_off[0]});
      chk("m_offset", 32'(bus.offset), 32'(m_off));
      chk("m_hwdata", bus.hwdata, m_wdata);
      chk("m_hrdata_out", bus.hrdata_out, m_rdata);
    end
  end

  task automatic set_req(input bit s, input bit b, input bit d);
    bus.start = s; bus.burst = b; bus.data_ready = d;
  endtask

  initial begin
    hresetn = 1'b1;
    bus.start = 0; bus.burst = 0; bus.data_ready = 0; bus.hwrite_in = 1;
    bus.haddrin = 0; bus.hwdatain = 0; bus.hsize_in = HSIZE_WORD; bus.offset_in = 0;
    bus.hready = 1; bus.hresp = 0; bus.hrdata = 0;

    // Reset
    tick();
    chk("rst_htrans", 32'(bus.htrans), 32'h0);
    chk("rst_haddr", bus.haddr, 32'h0);
    chk("rst_hburst", 32'(bus.hburst), 32'h0);
    chk("rst_hwdata", bus.hwdata, 32'h0);
    chk("rst_hrdata_out", bus.hrdata_out, 32'h0);
    hresetn = 1'b0;

    // Single write, then held request repeats NONSEQ
    set_req(1, 0, 1); bus.haddrin = 0; bus.hwdatain = 32'd5;
    tick();
    chk("single_htrans", 32'(bus.htrans), 32'h2);
    chk("single_haddr", bus.haddr, 32'h0);
    chk("single_hburst", 32'(bus.hburst), 32'h0);
    tick();
    chk("single_hwdata", bus.hwdata, 32'd5);
    chk("single_repeat", 32'(bus.htrans), 32'h2);
    set_req(0, 0, 0);
    tick();
    chk("single_idle", 32'(bus.htrans), 32'h0);

    // INCR burst with BUSY and termination
    set_req(1, 1, 1); bus.haddrin = 32'h4;
    tick();
    chk("incr_nonseq", {bus.haddr[29:0], bus.htrans}, {30'h4, 2'b10});
    chk("incr_hburst", 32'(bus.hburst), 32'h1);
    tick();
    chk("incr_seq8", {bus.haddr[29:0], bus.htrans}, {30'h8, 2'b11});
    tick();
    chk("incr_seqC", {bus.haddr[29:0], bus.htrans}, {30'hC, 2'b11});
    bus.data_ready = 0;
    tick();
    chk("incr_busy", {bus.haddr[29:0], bus.htrans}, {30'hC, 2'b01});
    bus.start = 0;
    tick();
    chk("incr_end", 32'(bus.htrans), 32'h0);

    // Wait states during SEQ
    set_req(1, 1, 1); bus.haddrin = 32'h100; bus.hwdatain = 32'h77;
    tick(); tick();
    chk("ws_seq", {bus.haddr[29:0], bus.htrans}, {30'h104, 2'b11});
    bus.hready = 0; bus.hwdatain = 32'h99;
    for (int i = 0; i < 5; i++) begin
      set_req(i[0], i[1], ~i[0]);
      tick();
      chk("ws_hold", {bus.haddr[29:0], bus.htrans}, {30'h104, 2'b11});
      chk("ws_hwdata", bus.hwdata, 32'h77);
    end
    bus.hready = 1; set_req(1, 1, 1);
    tick();
    chk("ws_resume", {bus.haddr[29:0], bus.htrans}, {30'h108, 2'b11});
    chk("ws_resume_data", bus.hwdata, 32'h99);
    set_req(0, 0, 0);
    tick();

    // Two-cycle ERROR response
    set_req(1, 0, 1); bus.haddrin = 0;
    tick();
    chk("err_nonseq", 32'(bus.htrans), 32'h2);
    set_req(0, 0, 0); bus.hready = 0; bus.hresp = 1;
    tick();
    chk("err_idle", 32'(bus.htrans), 32'h0);
    bus.hready = 1;
    tick();
    bus.hresp = 0;
    tick();
    chk("err_stay_idle", 32'(bus.htrans), 32'h0);

    // Single read
    bus.hwrite_in = 0; set_req(1, 0, 1); bus.haddrin = 32'h10;
    tick();
    chk("rd_addr", {bus.haddr[29:0], bus.htrans}, {30'h10, 2'b10});
    set_req(0, 0, 0); bus.hrdata = 32'hDEADBEEF;
    tick(); tick();
    chk("rd_data", bus.hrdata_out, 32'hDEADBEEF);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      hresetn        = ($urandom_range(0, 99) < 2);
      bus.start      = ($urandom_range(0, 99) < 80);
      bus.burst      = ($urandom_range(0, 99) < 70);
      bus.data_ready = ($urandom_range(0, 99) < 75);
      bus.hwrite_in  = $urandom_range(0, 1) == 1;
      bus.haddrin    = $urandom;
      bus.hwdatain   = $urandom;
      bus.hsize_in   = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 3));
      bus.offset_in  = 2'($urandom_range(0, 3));
      bus.hready     = ($urandom_range(0, 99) < 80);
      bus.hresp      = ($urandom_range(0, 99) < 5);
      bus.hrdata     = $urandom;
      tick();
    end

    @(posedge hclk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
